gcd_arbiter: RTL and testbench
==============================

# gcd_arbiter

Round-robin arbiter and sequencer that shares one `ee354_GCD` core among `NREQ` requesters. It accepts a single operand pair at a time over a valid/ready handshake. It drives the core's Start/Ack protocol and returns the result with the requester's ID over a held response handshake. It sits between the requesting units and the core, and shares the core's `Clk`, `Reset` and `CEN`.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `W`, default 8: operand/result width; must match the core.
- `Clk` — in, 1: clock, rising edge.
- `Reset` — in, 1: reset, synchronous, active-high.
- `CEN` — in, 1: clock enable; all state frozen when 0.
- `req_valid` — in, NREQ: request i pending; requester holds operands until accepted.
- `req_a`, `req_b` — in, NREQ*W: operands; requester i uses bits `[i*W +: W]`.
- `req_ready` — out, NREQ: one-hot accept; transfer at an edge with `req_valid[i] & req_ready[i] & CEN`.
- `rsp_valid` — out, 1: result available, held until acknowledged.
- `rsp_id` — out, `$clog2(NREQ)`: index of the requester that owns the result.
- `rsp_gcd` — out, W: GCD result.
- `rsp_ack` — in, NREQ: consumer acknowledge; only bit `rsp_id` is honoured.
- `core_Start`, `core_Ack` — out, 1: pulses to the core.
- `core_Ain`, `core_Bin` — out, W: latched operands to the core.
- `core_gcd` — in, W: core `AB_GCD`.
- `core_done` — in, 1: core `q_Done`.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, ACK, RESP. Nothing advances on an edge with `CEN`=0.
- **IDLE:**
  - `req_ready` is combinational: one-hot winner among `req_valid`. The search starts at `ptr+1` and wraps modulo NREQ.
  - `req_ready` is 0 in every other state.
  - On accept: latch operands into `core_Ain`/`core_Bin`, latch the ID, and set `ptr` to the winner.
  - If either operand is 0, go to RESP with `rsp_gcd = a | b` (gcd(x,0)=x, gcd(0,0)=0); the core is not started. Otherwise go to LAUNCH.
- **LAUNCH:** `core_Start`=1 for exactly this cycle. Next state is WAIT.
- **WAIT:** hold until `core_done` is sampled 1. At that edge, latch `core_gcd` into `rsp_gcd`, then go to ACK.
- **ACK:** `core_Ack`=1 for exactly this cycle. Next state is RESP.
- **RESP:**
  - `rsp_valid`=1, `rsp_id` and `rsp_gcd` are stable.
  - Go to IDLE on the edge where `rsp_ack[rsp_id]`=1. All other `rsp_ack` bits are ignored.
  - New requests are not accepted until IDLE.
- **Reset values:**
  - State IDLE; `ptr` = NREQ-1, so requester 0 wins first.
  - `core_Start`, `core_Ack`, `rsp_valid` = 0.
  - `rsp_id`, `rsp_gcd`, `core_Ain`, `core_Bin` = 0.
- **Reset mid-operation (any state):** the arbiter returns to IDLE on the next edge. The in-flight job is dropped with no response. The core is reset by the same `Reset`.
- `req_valid` dropped before accept: the request is withdrawn and the winner is re-evaluated in the same cycle.

## Timing
- Accept edge T0 → LAUNCH during cycle T0+1 → WAIT from T0+2.
- `core_done` sampled at edge Td → ACK cycle Td+1 → `rsp_valid` from Td+2.
- Zero-operand bypass: `rsp_valid` high in the cycle right after the accept edge.
- Fastest turnaround: `rsp_ack` edge → IDLE next cycle → next accept possible in that cycle.
- With `CEN` low, every registered output holds its value, and `core_Start`/`core_Ack` stay at their current level.

## Configuration
- **`GCD_ARB_CYCLE_CNT_EN` defined:**
  - Adds output `busy_cycles` [15:0].
  - It counts `CEN`-enabled cycles from LAUNCH through the `core_done` edge, saturating at 16'hFFFF.
  - It is latched together with `rsp_gcd`, is 0 for bypass jobs, and resets to 0.
- **Undefined:** no port and no counter logic.

## Test plan
- **Single request:** reset, then `req_valid`=4'b0001 with a=36, b=24.
  - `core_Start` one cycle, then `core_Ack` one cycle.
  - `rsp_valid` with `rsp_id`=0 and `rsp_gcd`=12; after `rsp_ack`=4'b0001, IDLE.
- **Round-robin fairness:** all four requesters valid from reset with (12,18), (15,5), (7,3), (63,42).
  - Grants in order 0,1,2,3; results 6, 5, 1, 21.
  - Then only requesters 0 and 2 kept valid: order 0,2,0,2.
- **Zero bypass:** a=0, b=15 → `rsp_gcd`=15 one cycle after accept, `core_Start` never asserted. a=0, b=0 → `rsp_gcd`=0.
- **CEN freeze:** `CEN`=0 for 10 cycles while in WAIT with `core_done`=1 already.
  - No transition and all outputs unchanged.
  - ACK follows on the first enabled edge; result unchanged (gcd(36,24)=12).
- **Reset mid-job:** `Reset` asserted during WAIT.
  - Next cycle shows all reset values and no `rsp_valid`.
  - Requester 0 wins even if requester 1 was pending.
- **Wrong ack:** in RESP with `rsp_id`=2, `rsp_ack`=4'b1011 held for 5 cycles → stays in RESP; `rsp_ack`=4'b0100 → IDLE next cycle.

Source files
------------

// File: rtl/gcd_arbiter.sv
// Round-robin front end that shares one ee354_GCD core among NREQ requesters.
// Optional busy-cycle counter output is enabled by defining GCD_ARB_CYCLE_CNT_EN.
module gcd_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            CEN,
    input  logic [NREQ-1:0] req_valid,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0] req_ready,
    output logic            rsp_valid,
    output logic [IW-1:0]   rsp_id,
    output logic [W-1:0]    rsp_gcd,
    input  logic [NREQ-1:0] rsp_ack,
    output logic            core_Start,
    output logic            core_Ack,
    output logic [W-1:0]    core_Ain,
    output logic [W-1:0]    core_Bin,
    input  logic [W-1:0]    core_gcd,
    input  logic            core_done
`ifdef GCD_ARB_CYCLE_CNT_EN
    ,
    output logic [15:0]     busy_cycles
`endif
);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        ACK,
        RESP
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] id_q, id_d;
    logic [W-1:0]  ain_q, ain_d;
    logic [W-1:0]  bin_q, bin_d;
    logic [W-1:0]  gcd_q, gcd_d;
    logic [IW-1:0] win;
    logic          found;
    logic [W-1:0]  a_sel, b_sel;

`ifdef GCD_ARB_CYCLE_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] busy_q, busy_d;
    logic [15:0] cnt_inc;
`endif

    // Two passes: indices above ptr first, then wrap to those at or below it.
    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && (IW'(i) > ptr_q)) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!found && req_valid[i] && (IW'(i) <= ptr_q)) begin
                found = 1'b1;
                win   = IW'(i);
            end
        end
    end

    always_comb begin
        a_sel     = '0;
        b_sel     = '0;
        req_ready = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == win) begin
                a_sel = req_a[i*W +: W];
                b_sel = req_b[i*W +: W];
                req_ready[i] = (state_q == IDLE) && found;
            end
        end
    end

`ifdef GCD_ARB_CYCLE_CNT_EN
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        ain_d   = ain_q;
        bin_d   = bin_q;
        gcd_d   = gcd_q;
`ifdef GCD_ARB_CYCLE_CNT_EN
        cnt_d   = cnt_q;
        busy_d  = busy_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    ain_d = a_sel;
                    bin_d = b_sel;
                    id_d  = win;
                    ptr_d = win;
`ifdef GCD_ARB_CYCLE_CNT_EN
                    cnt_d = '0;
`endif
                    // gcd(x,0)=x and gcd(0,0)=0, so OR gives the answer.
                    if (a_sel == '0 || b_sel == '0) begin
                        gcd_d   = a_sel | b_sel;
                        state_d = RESP;
`ifdef GCD_ARB_CYCLE_CNT_EN
                        busy_d  = '0;
`endif
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                state_d = WAIT;
`ifdef GCD_ARB_CYCLE_CNT_EN
                cnt_d   = cnt_inc;
`endif
            end
            WAIT: begin
`ifdef GCD_ARB_CYCLE_CNT_EN
                cnt_d = cnt_inc;
`endif
                if (core_done) begin
                    gcd_d   = core_gcd;
                    state_d = ACK;
`ifdef GCD_ARB_CYCLE_CNT_EN
                    busy_d  = cnt_inc;
`endif
                end
            end
            ACK: begin
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ack[id_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            ptr_q   <= IW'(NREQ - 1);
            id_q    <= '0;
            ain_q   <= '0;
            bin_q   <= '0;
            gcd_q   <= '0;
`ifdef GCD_ARB_CYCLE_CNT_EN
            cnt_q   <= '0;
            busy_q  <= '0;
`endif
        end else if (CEN) begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            ain_q   <= ain_d;
            bin_q   <= bin_d;
            gcd_q   <= gcd_d;
`ifdef GCD_ARB_CYCLE_CNT_EN
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
`endif
        end
    end

    assign core_Start = (state_q == LAUNCH);
    assign core_Ack   = (state_q == ACK);
    assign rsp_valid  = (state_q == RESP);
    assign rsp_id     = id_q;
    assign rsp_gcd    = gcd_q;
    assign core_Ain   = ain_q;
    assign core_Bin   = bin_q;
`ifdef GCD_ARB_CYCLE_CNT_EN
    assign busy_cycles = busy_q;
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// Self-checking bench for gcd_arbiter: directed scenarios plus a randomized
// run against a round-robin/Euclid reference model and a behavioural GCD core.
module tb_gcd_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        CEN;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_gcd;
    logic [3:0]  rsp_ack;
    logic        core_Start;
    logic        core_Ack;
    logic [7:0]  core_Ain;
    logic [7:0]  core_Bin;
    logic [7:0]  core_gcd = '0;
    logic        core_done = 1'b0;
`ifdef GCD_ARB_CYCLE_CNT_EN
    logic [15:0] busy_cycles;
`endif

    int errors = 0;
    int checks = 0;
    int start_cnt = 0;
    int ack_cnt = 0;
    logic [3:0] last_acc = '0;
    int force_lat = -1;

    logic m_busy = 1'b0;
    int   m_cnt = 0;

    gcd_arbiter #(.NREQ(NREQ), .W(W)) dut (
        .Clk(Clk),
        .Reset(Reset),
        .CEN(CEN),
        .req_valid(req_valid),
        .req_a(req_a),
        .req_b(req_b),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_gcd(rsp_gcd),
        .rsp_ack(rsp_ack),
        .core_Start(core_Start),
        .core_Ack(core_Ack),
        .core_Ain(core_Ain),
        .core_Bin(core_Bin),
        .core_gcd(core_gcd),
        .core_done(core_done)
`ifdef GCD_ARB_CYCLE_CNT_EN
        ,
        .busy_cycles(busy_cycles)
`endif
    );

    always #5 Clk = ~Clk;

    function automatic int ref_gcd(int a, int b);
        int x = a;
        int y = b;
        int t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    function automatic int rr_win(logic [3:0] v, int p);
        for (int k = 1; k <= NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic int idx_of(logic [3:0] oh);
        for (int i = 0; i < NREQ; i++) begin
            if (oh[i]) return i;
        end
        return -1;
    endfunction

    // Behavioural core: latches operands on Start, raises done after a delay,
    // holds done until Ack.
    always @(posedge Clk) begin
        if (Reset) begin
            core_done <= 1'b0;
            m_busy    <= 1'b0;
            m_cnt     <= 0;
            core_gcd  <= '0;
        end else if (CEN) begin
            if (core_Ack) begin
                core_done <= 1'b0;
                m_busy    <= 1'b0;
            end else if (core_Start) begin
                m_busy   <= 1'b1;
                m_cnt    <= (force_lat >= 0) ? force_lat : int'($urandom_range(0, 4));
                core_gcd <= 8'(ref_gcd(int'(core_Ain), int'(core_Bin)));
            end else if (m_busy && !core_done) begin
                if (m_cnt == 0) core_done <= 1'b1;
                else m_cnt <= m_cnt - 1;
            end
        end
    end

    task automatic step();
        logic [3:0] acc;
        #1;
        acc = req_ready & req_valid & {4{CEN & ~Reset}};
        start_cnt += int'(core_Start);
        ack_cnt   += int'(core_Ack);
        @(posedge Clk);
        @(negedge Clk);
        req_valid = req_valid & ~acc;
        last_acc  = acc;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        CEN = 1'b1;
        req_valid = '0;
        rsp_ack = '0;
        step();
        step();
        Reset = 1'b0;
    endtask

    task automatic wait_acc(input int limit);
        int n = 0;
        do begin
            step();
            n++;
        end while (last_acc == '0 && n < limit);
        checks++;
        if (last_acc == '0) begin
            errors++;
            $display("FAIL wait_acc: no grant within %0d cycles", limit);
        end
    endtask

    task automatic wait_rsp(input int limit);
        int n = 0;
        while (!rsp_valid && n < limit) begin
            step();
            n++;
        end
        checks++;
        if (!rsp_valid) begin
            errors++;
            $display("FAIL wait_rsp: rsp_valid not seen within %0d cycles", limit);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        CEN = 1'b1;
        req_valid = '0;
        rsp_ack = '0;
        req_a = '0;
        req_b = '0;
        step();
        step();
        checks++;
        if ({rsp_valid, core_Start, core_Ack} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 000", {rsp_valid, core_Start, core_Ack});
        end
        checks++;
        if ({rsp_id, rsp_gcd, core_Ain, core_Bin} !== 26'd0) begin
            errors++;
            $display("FAIL reset_data: id=%0d gcd=%0d ain=%0d bin=%0d want all 0",
                     rsp_id, rsp_gcd, core_Ain, core_Bin);
        end
        Reset = 1'b0;
        req_valid = 4'hF;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL reset_first_winner: got %b want 0001", req_ready);
        end
        req_valid = '0;
        #1;
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++;
            $display("FAIL ready_idle_none: got %b want 0000", req_ready);
        end
    endtask

    task automatic test_single();
        req_a = '0;
        req_b = '0;
        req_a[7:0] = 8'd36;
        req_b[7:0] = 8'd24;
        req_valid = 4'b0001;
        start_cnt = 0;
        ack_cnt = 0;
        wait_acc(5);
        checks++;
        if (last_acc !== 4'b0001) begin
            errors++;
            $display("FAIL single_grant: got %b want 0001", last_acc);
        end
        checks++;
        if (core_Start !== 1'b1 || core_Ain !== 8'd36 || core_Bin !== 8'd24) begin
            errors++;
            $display("FAIL single_launch: start=%b ain=%0d bin=%0d want 1 36 24",
                     core_Start, core_Ain, core_Bin);
        end
        step();
        checks++;
        if (core_Start !== 1'b0) begin
            errors++;
            $display("FAIL single_start_len: got %b want 0", core_Start);
        end
        wait_rsp(40);
        checks++;
        if (rsp_id !== 2'd0 || rsp_gcd !== 8'd12) begin
            errors++;
            $display("FAIL single_rsp: id=%0d gcd=%0d want 0 12", rsp_id, rsp_gcd);
        end
        checks++;
        if (start_cnt != 1 || ack_cnt != 1) begin
            errors++;
            $display("FAIL single_pulses: start=%0d ack=%0d want 1 1", start_cnt, ack_cnt);
        end
        rsp_ack = 4'b0001;
        step();
        rsp_ack = '0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_release: rsp_valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int ord1[4] = '{0, 1, 2, 3};
        int gcd1[4] = '{6, 5, 1, 21};
        int ord2[4] = '{0, 2, 0, 2};
        int id;
        do_reset();
        req_a = {8'd63, 8'd7, 8'd15, 8'd12};
        req_b = {8'd42, 8'd3, 8'd5, 8'd18};
        req_valid = 4'hF;
        for (int j = 0; j < 4; j++) begin
            wait_acc(10);
            id = idx_of(last_acc);
            checks++;
            if (id != ord1[j]) begin
                errors++;
                $display("FAIL rr_grant%0d: got %0d want %0d", j, id, ord1[j]);
            end
            wait_rsp(40);
            checks++;
            if (int'(rsp_id) != ord1[j] || int'(rsp_gcd) != gcd1[j]) begin
                errors++;
                $display("FAIL rr_rsp%0d: id=%0d gcd=%0d want %0d %0d",
                         j, rsp_id, rsp_gcd, ord1[j], gcd1[j]);
            end
            rsp_ack = 4'b0001 << rsp_id;
            step();
            rsp_ack = '0;
        end
        req_valid = 4'b0101;
        for (int j = 0; j < 4; j++) begin
            wait_acc(10);
            id = idx_of(last_acc);
            req_valid = req_valid | last_acc;
            checks++;
            if (id != ord2[j]) begin
                errors++;
                $display("FAIL rr2_grant%0d: got %0d want %0d", j, id, ord2[j]);
            end
            wait_rsp(40);
            checks++;
            if (int'(rsp_gcd) != gcd1[ord2[j]]) begin
                errors++;
                $display("FAIL rr2_rsp%0d: gcd=%0d want %0d", j, rsp_gcd, gcd1[ord2[j]]);
            end
            rsp_ack = 4'b0001 << rsp_id;
            step();
            rsp_ack = '0;
        end
        req_valid = '0;
    endtask

    task automatic test_zero_bypass();
        req_a[15:8] = 8'd0;
        req_b[15:8] = 8'd15;
        req_a[31:24] = 8'd0;
        req_b[31:24] = 8'd0;
        start_cnt = 0;
        req_valid = 4'b0010;
        wait_acc(10);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_gcd !== 8'd15 || rsp_id !== 2'd1) begin
            errors++;
            $display("FAIL bypass_0_15: valid=%b gcd=%0d id=%0d want 1 15 1",
                     rsp_valid, rsp_gcd, rsp_id);
        end
        rsp_ack = 4'b0010;
        step();
        rsp_ack = '0;
        req_valid = 4'b1000;
        wait_acc(10);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_gcd !== 8'd0 || rsp_id !== 2'd3) begin
            errors++;
            $display("FAIL bypass_0_0: valid=%b gcd=%0d id=%0d want 1 0 3",
                     rsp_valid, rsp_gcd, rsp_id);
        end
        rsp_ack = 4'b1000;
        step();
        rsp_ack = '0;
        checks++;
        if (start_cnt != 0) begin
            errors++;
            $display("FAIL bypass_no_start: start pulses=%0d want 0", start_cnt);
        end
    endtask

    task automatic test_cen_freeze();
        logic [28:0] snap;
        int n = 0;
        force_lat = 3;
        req_a[23:16] = 8'd36;
        req_b[23:16] = 8'd24;
        req_valid = 4'b0100;
        wait_acc(10);
        while (!core_done && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!core_done || core_Ack || rsp_valid) begin
            errors++;
            $display("FAIL freeze_setup: done=%b ack=%b valid=%b want 1 0 0",
                     core_done, core_Ack, rsp_valid);
        end
        CEN = 1'b0;
        snap = {rsp_valid, core_Start, core_Ack, rsp_id, rsp_gcd, core_Ain, core_Bin};
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if ({rsp_valid, core_Start, core_Ack, rsp_id, rsp_gcd, core_Ain, core_Bin} !== snap
                || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL freeze_hold%0d: got %h want %h", k,
                         {rsp_valid, core_Start, core_Ack, rsp_id, rsp_gcd, core_Ain, core_Bin},
                         snap);
            end
        end
        CEN = 1'b1;
        step();
        checks++;
        if (core_Ack !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL freeze_ack: ack=%b valid=%b want 1 0", core_Ack, rsp_valid);
        end
        step();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_gcd !== 8'd12 || rsp_id !== 2'd2 || core_Ack !== 1'b0) begin
            errors++;
            $display("FAIL freeze_rsp: valid=%b gcd=%0d id=%0d ack=%b want 1 12 2 0",
                     rsp_valid, rsp_gcd, rsp_id, core_Ack);
        end
        rsp_ack = 4'b0100;
        step();
        rsp_ack = '0;
        force_lat = -1;
    endtask

    task automatic test_reset_mid();
        force_lat = 20;
        req_a[7:0] = 8'd36;
        req_b[7:0] = 8'd24;
        req_a[15:8] = 8'd50;
        req_b[15:8] = 8'd35;
        req_valid = 4'b0001;
        wait_acc(10);
        step();
        step();
        step();
        req_valid = 4'b0011;
        Reset = 1'b1;
        step();
        checks++;
        if ({rsp_valid, core_Start, core_Ack, rsp_id, rsp_gcd, core_Ain, core_Bin} !== 29'd0) begin
            errors++;
            $display("FAIL midreset_vals: got %h want 0",
                     {rsp_valid, core_Start, core_Ack, rsp_id, rsp_gcd, core_Ain, core_Bin});
        end
        Reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_winner: got %b want 0001", req_ready);
        end
        wait_acc(10);
        checks++;
        if (last_acc !== 4'b0001) begin
            errors++;
            $display("FAIL midreset_grant: got %b want 0001", last_acc);
        end
        wait_rsp(60);
        checks++;
        if (rsp_id !== 2'd0 || rsp_gcd !== 8'd12) begin
            errors++;
            $display("FAIL midreset_rsp: id=%0d gcd=%0d want 0 12", rsp_id, rsp_gcd);
        end
        rsp_ack = 4'b0001;
        step();
        rsp_ack = '0;
        req_valid = '0;
        force_lat = -1;
    endtask

    task automatic test_wrong_ack();
        req_a[23:16] = 8'd0;
        req_b[23:16] = 8'd9;
        req_valid = 4'b0100;
        wait_acc(10);
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_gcd !== 8'd9) begin
            errors++;
            $display("FAIL wack_setup: valid=%b id=%0d gcd=%0d want 1 2 9",
                     rsp_valid, rsp_id, rsp_gcd);
        end
        rsp_ack = 4'b1011;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2) begin
                errors++;
                $display("FAIL wack_hold%0d: valid=%b id=%0d want 1 2", k, rsp_valid, rsp_id);
            end
        end
        rsp_ack = 4'b0100;
        step();
        rsp_ack = '0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL wack_release: valid=%b want 0", rsp_valid);
        end
    endtask

    task automatic test_random();
        int exp_ptr = NREQ - 1;
        bit busy = 1'b0;
        bit seen = 1'b0;
        int exp_id = 0;
        int exp_g = 0;
        int jobs = 0;
        int cyc = 0;
        int w;
        logic [3:0] v_before;
        logic [3:0] exp_acc;
        logic [3:0] noise;
        bit ack_edge;
        do_reset();
        while (jobs < 60 && cyc < 4000) begin
            cyc++;
            CEN = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i] = 1'b1;
                    req_a[i*W +: W] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                    req_b[i*W +: W] = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
                end else if (req_valid[i] && $urandom_range(0, 19) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            noise = 4'($urandom_range(0, 15));
            if (rsp_valid) begin
                if ($urandom_range(0, 2) == 0) rsp_ack = noise | (4'b0001 << exp_id);
                else rsp_ack = noise & ~(4'b0001 << exp_id);
            end else begin
                rsp_ack = noise;
            end
            #1;
            if (rsp_valid) begin
                checks++;
                if (!busy) begin
                    errors++;
                    $display("FAIL rnd_spurious_rsp: cycle %0d rsp_valid with no job", cyc);
                end else if (!seen) begin
                    seen = 1'b1;
                    checks++;
                    if (int'(rsp_id) != exp_id || int'(rsp_gcd) != exp_g) begin
                        errors++;
                        $display("FAIL rnd_rsp: cycle %0d id=%0d gcd=%0d want %0d %0d",
                                 cyc, rsp_id, rsp_gcd, exp_id, exp_g);
                    end
                end
            end
            if (busy) begin
                checks++;
                if (req_ready !== 4'b0000) begin
                    errors++;
                    $display("FAIL rnd_ready_busy: cycle %0d got %b want 0000", cyc, req_ready);
                end
            end
            ack_edge = CEN && rsp_valid && rsp_ack[exp_id];
            v_before = req_valid;
            exp_acc = '0;
            if (!busy && CEN && v_before != '0) exp_acc = 4'b0001 << rr_win(v_before, exp_ptr);
            step();
            checks++;
            if (last_acc !== exp_acc) begin
                errors++;
                $display("FAIL rnd_grant: cycle %0d got %b want %b", cyc, last_acc, exp_acc);
            end
            if (ack_edge) begin
                busy = 1'b0;
                seen = 1'b0;
                checks++;
                if (rsp_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_release: cycle %0d rsp_valid=%b want 0", cyc, rsp_valid);
                end
            end
            if (exp_acc != '0) begin
                w = idx_of(exp_acc);
                exp_ptr = w;
                exp_id = w;
                exp_g = ref_gcd(int'(req_a[w*W +: W]), int'(req_b[w*W +: W]));
                busy = 1'b1;
                jobs++;
            end
        end
        checks++;
        if (jobs < 60) begin
            errors++;
            $display("FAIL rnd_progress: jobs=%0d want 60", jobs);
        end
        CEN = 1'b1;
        req_valid = '0;
        rsp_ack = '0;
    endtask

    initial begin
        Reset = 1'b1;
        CEN = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ack = '0;
        @(negedge Clk);
        test_reset();
        test_single();
        test_round_robin();
        test_zero_bypass();
        test_cen_freeze();
        test_reset_mid();
        test_wrong_ack();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
